// File: rtl/sysid_pkg.sv
// rtl/sysid_pkg.sv - register map, CAPS layout and limits for sysid_regs
package sysid_pkg;

    localparam int ADDR_ID        = 0;
    localparam int ADDR_TIMESTAMP = 1;
    localparam int ADDR_CAPS      = 2;
    localparam int ADDR_UPTIME_LO = 3;
    localparam int ADDR_UPTIME_HI = 4;
    localparam int ADDR_SECONDS   = 5;
    localparam int ADDR_SCRATCH0  = 6;

    localparam int CAPS_NSCRATCH_LSB = 0;
    localparam int CAPS_RLAT_LSB     = 8;
    localparam int CAPS_UPTIME_BIT   = 12;
    localparam int CAPS_ADDRW_LSB    = 16;

    localparam int READ_LATENCY_MIN = 1;
    localparam int READ_LATENCY_MAX = 4;
    localparam int NUM_SCRATCH_MAX  = 8;
    localparam int ADDR_W_MIN       = 4;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
    } rd_resp_t;

    function automatic logic [31:0] caps_word(input int num_scratch, input int read_latency,
                                              input int addr_w, input logic uptime_en);
        logic [31:0] w;
        w = '0;
        w[CAPS_NSCRATCH_LSB +: 8] = 8'(num_scratch);
        w[CAPS_RLAT_LSB +: 4]     = 4'(read_latency);
        w[CAPS_UPTIME_BIT]        = uptime_en;
        w[CAPS_ADDRW_LSB +: 16]   = 16'(addr_w);
        return w;
    endfunction

endpackage

// File: rtl/sysid_read_pipe.sv
// rtl/sysid_read_pipe.sv - fixed-depth valid/data delay line for read responses
module sysid_read_pipe
    import sysid_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        out_valid,
    output logic [31:0] out_data
);

    rd_resp_t stage [DEPTH];

    // Data is zeroed at entry when not valid, so the output bus is 0 whenever valid is low.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= in_valid ? rd_resp_t'({1'b1, in_data}) : rd_resp_t'('0);
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign out_valid = stage[DEPTH-1].valid;
    assign out_data  = stage[DEPTH-1].data;

endmodule

// File: rtl/sysid_regs.sv
// rtl/sysid_regs.sv - system-ID register slave; SYSID_UPTIME_EN adds uptime/seconds counters
module sysid_regs
    import sysid_pkg::*;
#(
    parameter logic [31:0] ID           = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
    parameter int          ADDR_W       = 4,
    parameter int          READ_LATENCY = 1,
    parameter int          NUM_SCRATCH  = 2,
    parameter int          CLK_HZ       = 50_000_000
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              readdatavalid
);

    localparam int SCR_N = (NUM_SCRATCH > 0) ? NUM_SCRATCH : 1;
`ifdef SYSID_UPTIME_EN
    localparam logic UPTIME_PRESENT = 1'b1;
`else
    localparam logic UPTIME_PRESENT = 1'b0;
`endif
    localparam logic [31:0] CAPS = caps_word(NUM_SCRATCH, READ_LATENCY, ADDR_W, UPTIME_PRESENT);

    logic [31:0] addr;
    logic        wr_en;
    logic [31:0] rd_data;
    logic [31:0] scratch [SCR_N];

    assign addr  = 32'(address);
    // A read in the same cycle as a write takes priority; the write is dropped.
    assign wr_en = write & ~read;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SCR_N; i++) scratch[i] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (addr == 32'(ADDR_SCRATCH0 + i)) scratch[i] <= writedata;
            end
        end
    end

`ifdef SYSID_UPTIME_EN
    logic [63:0] uptime;
    logic [31:0] snapshot;
    logic [31:0] prescaler;
    logic [31:0] seconds;

    // Reading the low word freezes the high word so software sees a coherent 64-bit value.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            uptime    <= '0;
            snapshot  <= '0;
            prescaler <= '0;
            seconds   <= '0;
        end else begin
            if (wr_en && addr == 32'(ADDR_UPTIME_LO)) begin
                uptime   <= '0;
                snapshot <= '0;
            end else begin
                uptime <= uptime + 64'd1;
                if (read && addr == 32'(ADDR_UPTIME_LO)) snapshot <= uptime[63:32];
            end

            if (wr_en && addr == 32'(ADDR_SECONDS)) begin
                seconds   <= writedata;
                prescaler <= '0;
            end else if (prescaler == 32'(CLK_HZ - 1)) begin
                prescaler <= '0;
                seconds   <= seconds + 32'd1;
            end else begin
                prescaler <= prescaler + 32'd1;
            end
        end
    end
`endif

    always_comb begin
        rd_data = '0;
        case (addr)
            32'(ADDR_ID):        rd_data = ID;
            32'(ADDR_TIMESTAMP): rd_data = TIMESTAMP;
            32'(ADDR_CAPS):      rd_data = CAPS;
`ifdef SYSID_UPTIME_EN
            32'(ADDR_UPTIME_LO): rd_data = uptime[31:0];
            32'(ADDR_UPTIME_HI): rd_data = snapshot;
            32'(ADDR_SECONDS):   rd_data = seconds;
`endif
            default: begin
                for (int i = 0; i < NUM_SCRATCH; i++) begin
                    if (addr == 32'(ADDR_SCRATCH0 + i)) rd_data = scratch[i];
                end
            end
        endcase
    end

    sysid_read_pipe #(
        .DEPTH(READ_LATENCY)
    ) u_read_pipe (
        .clock    (clock),
        .reset_n  (reset_n),
        .in_valid (read),
        .in_data  (rd_data),
        .out_valid(readdatavalid),
        .out_data (readdata)
    );

endmodule

// File: tb/tb_sysid_regs.sv
// tb/tb_sysid_regs.sv - self-checking bench for sysid_regs with a cycle-level reference model
module tb_sysid_regs;

    localparam logic [31:0] ID_V = 32'h52CD_4EC5;
    localparam logic [31:0] TS_V = 32'h6650_1234;
    localparam int AW = 4;
    localparam int RL = 2;
    localparam int NS = 2;
    localparam int HZ = 10;
`ifdef SYSID_UPTIME_EN
    localparam bit          UP_EN    = 1'b1;
    localparam logic [31:0] CAPS_LIT = 32'h0004_1202;
`else
    localparam bit          UP_EN    = 1'b0;
    localparam logic [31:0] CAPS_LIT = 32'h0004_0202;
`endif

    logic          clock;
    logic          reset_n;
    logic [AW-1:0] address;
    logic          read;
    logic          write;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic          readdatavalid;

    sysid_regs #(
        .ID(ID_V), .TIMESTAMP(TS_V), .ADDR_W(AW),
        .READ_LATENCY(RL), .NUM_SCRATCH(NS), .CLK_HZ(HZ)
    ) dut (
        .clock(clock), .reset_n(reset_n), .address(address), .read(read),
        .write(write), .writedata(writedata), .readdata(readdata),
        .readdatavalid(readdatavalid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        longint      due;
        logic [31:0] data;
    } resp_t;

    int          checks = 0;
    int          passes = 0;
    longint      cyc = 0;
    longint      up_base = 0;
    longint      p_base = 0;
    logic [31:0] sec_load = 0;
    logic [31:0] snap = 0;
    logic [31:0] scr [NS];
    bit          force_on = 0;
    logic [63:0] force_val = 0;
    resp_t       exp_q[$];
    resp_t       got[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: counters are expressed as elapsed cycles since their last clear/load.
    logic [63:0] m_up;
    logic [31:0] m_sec;
    logic [31:0] m_d;
    int          m_a;
    always @(posedge clock) begin
        if (!reset_n) begin
            up_base  = cyc + 1;
            p_base   = cyc + 1;
            sec_load = 0;
            snap     = 0;
            foreach (scr[i]) scr[i] = 0;
        end else begin
            m_up  = force_on ? force_val : 64'(cyc - up_base);
            m_sec = sec_load + 32'((cyc - p_base) / HZ);
            m_a   = int'(address);
            if (read) begin
                m_d = 0;
                if (m_a == 0) m_d = ID_V;
                else if (m_a == 1) m_d = TS_V;
                else if (m_a == 2) m_d = 32'(NS) | (32'(RL) << 8) | (32'(UP_EN) << 12) | (32'(AW) << 16);
                else if (UP_EN && m_a == 3) m_d = m_up[31:0];
                else if (UP_EN && m_a == 4) m_d = snap;
                else if (UP_EN && m_a == 5) m_d = m_sec;
                else if (m_a >= 6 && m_a < 6 + NS) m_d = scr[m_a-6];
                exp_q.push_back('{cyc + RL, m_d});
                if (UP_EN && m_a == 3) snap = m_up[63:32];
            end else if (write) begin
                if (UP_EN && m_a == 3) begin
                    up_base = cyc + 1;
                    snap    = 0;
                end
                if (UP_EN && m_a == 5) begin
                    sec_load = writedata;
                    p_base   = cyc + 1;
                end
                if (m_a >= 6 && m_a < 6 + NS) scr[m_a-6] = writedata;
            end
        end
        cyc++;
    end

    always @(negedge reset_n) exp_q.delete();

    resp_t e;
    always @(negedge clock) begin
        if (!reset_n) begin
            check("reset_quiet", {readdatavalid, readdata}, 64'h0);
        end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            check("resp", {readdatavalid, readdata}, {31'h0, 1'b1, e.data});
        end else begin
            check("idle", {readdatavalid, readdata}, 64'h0);
        end
        if (readdatavalid === 1'b1) got.push_back('{cyc, readdata});
    end

    task automatic idle(input int n);
        read  = 0;
        write = 0;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        address = AW'(a); writedata = d; write = 1; read = 0;
        @(posedge clock);
        #1;
        write = 0;
    endtask

    task automatic rd_chk(input int a, input logic [31:0] exp, input string name);
        longint n;
        int     w;
        resp_t  r;
        got.delete();
        address = AW'(a); read = 1; write = 0;
        n = cyc;
        @(posedge clock);
        #1;
        read = 0;
        w = 0;
        while (got.size() == 0 && w < 10) begin
            @(posedge clock);
            #1;
            w++;
        end
        if (got.size() == 0) begin
            checks++;
            $display("FAIL %s_timeout: got no response expected one within 10 cycles", name);
        end else begin
            r = got.pop_front();
            check({name, "_data"}, r.data, exp);
            check({name, "_latency"}, r.due - n, RL);
        end
    endtask

    int          b2b_a [6] = '{0, 1, 6, 7, 2, 15};
    logic [31:0] b2b_e [6];

    initial begin
        reset_n = 0; read = 0; write = 0; address = 0; writedata = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_valid", readdatavalid, 0);
        check("reset_data", readdata, 0);
        @(posedge clock);
        #1 reset_n = 1;
        idle(2);

        rd_chk(0, ID_V, "id");
        rd_chk(1, TS_V, "timestamp");
        rd_chk(2, CAPS_LIT, "caps");

        wr(6, 32'hDEAD_BEEF);
        rd_chk(6, 32'hDEAD_BEEF, "scratch0");
        rd_chk(7, 32'h0, "scratch1_zero");

        address = 7; read = 1; write = 1; writedata = 32'h1234_5678;
        @(posedge clock);
        #1;
        idle(4);
        rd_chk(7, 32'h0, "rw_collision");

        wr(8, 32'hFFFF_FFFF);
        rd_chk(8, 32'h0, "unmapped8");
        rd_chk(15, 32'h0, "unmapped15");
        wr(7, 32'h0BAD_F00D);
        rd_chk(7, 32'h0BAD_F00D, "scratch1");

        b2b_e = '{ID_V, TS_V, 32'hDEAD_BEEF, 32'h0BAD_F00D, CAPS_LIT, 32'h0};
        got.delete();
        for (int i = 0; i < 6; i++) begin
            address = AW'(b2b_a[i]); read = 1;
            @(posedge clock);
            #1;
        end
        idle(RL + 2);
        check("b2b_count", got.size(), 6);
        if (got.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                check("b2b_data", got[i].data, b2b_e[i]);
                check("b2b_spacing", got[i].due - got[0].due, i);
            end
        end

`ifdef SYSID_UPTIME_EN
        wr(5, 0);
        idle(25);
        rd_chk(5, 32'd2, "seconds_after_25");
        wr(5, 100);
        idle(14);
        rd_chk(5, 32'd101, "seconds_after_load");

        got.delete();
        address = 3; read = 1;
        force_val = 64'h0000_0000_FFFF_FFFF;
        force dut.uptime = 64'h0000_0000_FFFF_FFFF;
        force_on = 1;
        @(posedge clock);
        #1;
        release dut.uptime;
        force_on = 0;
        read = 0;
        idle(4);
        check("uptime_lo_count", got.size(), 1);
        if (got.size() == 1) check("uptime_lo", got[0].data, 32'hFFFF_FFFF);
        rd_chk(4, 32'h0, "uptime_hi_snapshot");

        for (int i = 0; i < 10; i++) begin
            idle(i);
            wr(3, 32'h5555_5555);
            rd_chk(3, 32'h0, "uptime_clear");
        end
        for (int i = 0; i < 10; i++) begin
            idle(i);
            wr(5, 32'(1000 + i));
            rd_chk(5, 32'(1000 + i), "seconds_load_wins");
        end
        idle(7);
        rd_chk(4, 32'h0, "uptime_hi_after_clear");
`else
        rd_chk(3, 32'h0, "off_uptime_lo");
        rd_chk(4, 32'h0, "off_uptime_hi");
        rd_chk(5, 32'h0, "off_seconds");
        wr(5, 100);
        rd_chk(5, 32'h0, "off_seconds_write");
        wr(3, 32'h1);
        rd_chk(3, 32'h0, "off_uptime_write");
`endif

        got.delete();
        address = 0; read = 1;
        @(posedge clock);
        #1 address = 1;
        @(posedge clock);
        #1 address = 2;
        @(posedge clock);
        #1 address = 3;
        #6 reset_n = 0;
        @(posedge clock);
        #1 read = 0;
        @(posedge clock);
        #1 reset_n = 1;
        idle(8);
        check("reset_flush_count", got.size(), 2);
        if (got.size() == 2) begin
            check("reset_flush_first", got[0].data, ID_V);
            check("reset_flush_second", got[1].data, TS_V);
        end
        rd_chk(6, 32'h0, "scratch_after_reset");
        idle(2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
